// File: rtl/imm_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : imm_fetch_sequencer
// Brief    : Fetches OP-IMM instructions over req/ack, then sequences the
//            immediate-ALU enable, write-back strobe, PC and retire count.
//            Optional fetch timeout (bus_err) enabled by FETCH_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module imm_fetch_sequencer #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
`ifdef FETCH_TIMEOUT_EN
  parameter int          TIMEOUT_CYCLES = 16,
`endif
  parameter int          EXEC_CYCLES    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instruction,
  output logic        alu_imm_enable_n,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic [31:0] retire_count,
  output logic        illegal,
`ifdef FETCH_TIMEOUT_EN
  output logic        bus_err,
`endif
  output logic        halted
);

  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [3:0] c_EXEC_LAST = 4'(EXEC_CYCLES - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_instr;
  logic [31:0] w_instr_nxt;
  logic [31:0] r_retire;
  logic [31:0] w_retire_nxt;
  logic [3:0]  r_exec_cnt;
  logic [3:0]  w_exec_cnt_nxt;
  logic        r_illegal;
  logic        w_illegal_nxt;
  logic        r_mem_req;
  logic        r_en_n;
  logic        r_rf_we;
  logic        r_halted;

`ifdef FETCH_TIMEOUT_EN
  localparam int                c_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

  logic [c_TO_W-1:0] r_to_cnt;
  logic [c_TO_W-1:0] w_to_cnt_nxt;
  logic              r_bus_err;
  logic              w_bus_err_nxt;
`endif

  // Ack is only honoured once the request is actually on the bus, so an
  // ack lingering across reset release is never mistaken for a response.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_retire_nxt   = r_retire;
    w_exec_cnt_nxt = r_exec_cnt;
    w_illegal_nxt  = r_illegal;
`ifdef FETCH_TIMEOUT_EN
    w_to_cnt_nxt   = r_to_cnt;
    w_bus_err_nxt  = r_bus_err;
`endif
    case (r_state)
      S_FETCH: begin
        if (r_mem_req && mem_ack) begin
          w_instr_nxt = mem_rdata;
          w_state_nxt = S_DECODE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (r_mem_req) begin
          if (r_to_cnt == c_TO_LAST) begin
            w_bus_err_nxt = 1'b1;
            w_state_nxt   = S_HALT;
          end else begin
            w_to_cnt_nxt = r_to_cnt + 1'b1;
          end
        end
`endif
      end
      S_DECODE: begin
        if (r_instr[6:0] == c_OP_IMM) begin
          w_exec_cnt_nxt = 4'd0;
          w_state_nxt    = S_EXEC;
        end else begin
          w_illegal_nxt = 1'b1;
          w_state_nxt   = S_HALT;
        end
      end
      S_EXEC: begin
        if (r_exec_cnt == c_EXEC_LAST) begin
          w_state_nxt = S_WB;
        end else begin
          w_exec_cnt_nxt = r_exec_cnt + 4'd1;
        end
      end
      S_WB: begin
        w_pc_nxt     = r_pc + 32'd4;
        w_retire_nxt = r_retire + 32'd1;
        w_state_nxt  = S_FETCH;
`ifdef FETCH_TIMEOUT_EN
        w_to_cnt_nxt = '0;
`endif
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_HALT;
      end
    endcase
  end

  // Handshake and enable outputs are registered from the next state so they
  // line up exactly with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_instr    <= 32'd0;
      r_retire   <= 32'd0;
      r_exec_cnt <= 4'd0;
      r_illegal  <= 1'b0;
      r_mem_req  <= 1'b0;
      r_en_n     <= 1'b1;
      r_rf_we    <= 1'b0;
      r_halted   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      r_to_cnt   <= '0;
      r_bus_err  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_retire   <= w_retire_nxt;
      r_exec_cnt <= w_exec_cnt_nxt;
      r_illegal  <= w_illegal_nxt;
      r_mem_req  <= (w_state_nxt == S_FETCH);
      r_en_n     <= !((w_state_nxt == S_EXEC) || (w_state_nxt == S_WB));
      r_rf_we    <= (w_state_nxt == S_WB);
      r_halted   <= (w_state_nxt == S_HALT);
`ifdef FETCH_TIMEOUT_EN
      r_to_cnt   <= w_to_cnt_nxt;
      r_bus_err  <= w_bus_err_nxt;
`endif
    end
  end

  assign mem_addr         = r_pc;
  assign mem_req          = r_mem_req;
  assign instruction      = r_instr;
  assign alu_imm_enable_n = r_en_n;
  assign rf_we            = r_rf_we;
  assign pc               = r_pc;
  assign retire_count     = r_retire;
  assign illegal          = r_illegal;
  assign halted           = r_halted;
`ifdef FETCH_TIMEOUT_EN
  assign bus_err          = r_bus_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imm_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_fetch_sequencer
// Brief    : Directed self-checking bench for imm_fetch_sequencer with a
//            retire scoreboard; timeout steps run when FETCH_TIMEOUT_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] instruction;
  logic        alu_imm_enable_n;
  logic        rf_we;
  logic [31:0] pc;
  logic [31:0] retire_count;
  logic        illegal;
  logic        halted;
`ifdef FETCH_TIMEOUT_EN
  logic        bus_err;
  logic        t_bus_err;
`endif

  logic [31:0] t_mem_addr;
  logic        t_mem_req;
  logic        t_ack = 1'b0;
  logic [31:0] t_rdata = 32'd0;
  logic [31:0] t_instr;
  logic        t_en_n;
  logic        t_rf_we;
  logic [31:0] t_pc;
  logic [31:0] t_retire;
  logic        t_illegal;
  logic        t_halted;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb_pc[$];
  logic [31:0] sb_instr[$];

  imm_fetch_sequencer #(.RESET_PC(32'h0000_0000), .EXEC_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instruction(instruction), .alu_imm_enable_n(alu_imm_enable_n), .rf_we(rf_we),
    .pc(pc), .retire_count(retire_count), .illegal(illegal),
`ifdef FETCH_TIMEOUT_EN
    .bus_err(bus_err),
`endif
    .halted(halted)
  );

  imm_fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC), .EXEC_CYCLES(2)) dut_top (
    .clk(clk), .rst_n(rst_n),
    .mem_addr(t_mem_addr), .mem_req(t_mem_req), .mem_ack(t_ack), .mem_rdata(t_rdata),
    .instruction(t_instr), .alu_imm_enable_n(t_en_n), .rf_we(t_rf_we),
    .pc(t_pc), .retire_count(t_retire), .illegal(t_illegal),
`ifdef FETCH_TIMEOUT_EN
    .bus_err(t_bus_err),
`endif
    .halted(t_halted)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic hold_reset();
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    t_ack   = 1'b0;
    sb_pc.delete();
    sb_instr.delete();
    tick();
    tick();
  endtask

  // Release reset; the first edge afterwards raises the fetch request.
  task automatic release_reset();
    rst_n = 1'b1;
    tick();
  endtask

  // Entered in a FETCH cycle with the request up; returns in the next FETCH.
  task automatic do_instr(input logic [31:0] word, input int waits,
                          input logic [31:0] exp_pc, input logic [31:0] prev);
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    sb_pc.push_back(exp_pc);
    sb_instr.push_back(word);
    chk("fetch_req", 32'(mem_req), 32'd1);
    chk("fetch_addr", mem_addr, exp_pc);
    chk("fetch_en_n", 32'(alu_imm_enable_n), 32'd1);
    for (int i = 0; i < waits; i++) begin
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      tick();
      chk("wait_req", 32'(mem_req), 32'd1);
      chk("wait_instr", instruction, prev);
      chk("wait_en_n", 32'(alu_imm_enable_n), 32'd1);
    end
    mem_ack   = 1'b1;
    mem_rdata = word;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    chk("decode_instr", instruction, word);
    chk("decode_req", 32'(mem_req), 32'd0);
    chk("decode_en_n", 32'(alu_imm_enable_n), 32'd1);
    tick();
    chk("exec1_en_n", 32'(alu_imm_enable_n), 32'd0);
    chk("exec1_we", 32'(rf_we), 32'd0);
    tick();
    chk("exec2_en_n", 32'(alu_imm_enable_n), 32'd0);
    chk("exec2_we", 32'(rf_we), 32'd0);
    tick();
    chk("wb_we", 32'(rf_we), 32'd1);
    chk("wb_en_n", 32'(alu_imm_enable_n), 32'd0);
    checks++;
    assert (sb_pc.size() > 0) else begin
      errors++;
      $error("FAIL sb_empty observed=0 expected=entry");
    end
    if (sb_pc.size() > 0) begin
      e_pc    = sb_pc.pop_front();
      e_instr = sb_instr.pop_front();
      chk("sb_pc", pc, e_pc);
      chk("sb_instr", instruction, e_instr);
    end
    tick();
    chk("next_req", 32'(mem_req), 32'd1);
    chk("next_pc", pc, exp_pc + 32'd4);
    chk("next_en_n", 32'(alu_imm_enable_n), 32'd1);
    chk("next_we", 32'(rf_we), 32'd0);
  endtask

  initial begin
    // Reset state and a single addi x1,x2,5
    hold_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_en_n", 32'(alu_imm_enable_n), 32'd1);
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_retire", retire_count, 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_top_pc", t_pc, 32'hFFFF_FFFC);
`ifdef FETCH_TIMEOUT_EN
    chk("rst_bus_err", 32'(bus_err), 32'd0);
`endif
    release_reset();
    do_instr(32'h0051_0093, 0, 32'h0, 32'h0);
    chk("t1_retire", retire_count, 32'd1);

    // Three back-to-back OP-IMM words, the second with three wait cycles
    hold_reset();
    release_reset();
    do_instr(32'h0011_0113, 0, 32'h0, 32'h0);
    do_instr(32'hFFF1_8193, 3, 32'h4, 32'h0011_0113);
    do_instr(32'h0072_7213, 0, 32'h8, 32'hFFF1_8193);
    chk("t2_retire", retire_count, 32'd3);
    chk("t2_pc", pc, 32'd12);

    // Non OP-IMM opcode halts with illegal; later acks are ignored
    hold_reset();
    release_reset();
    chk("t3_addr", mem_addr, 32'h0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0033;
    tick();
    mem_ack = 1'b0;
    chk("t3_dec_illegal", 32'(illegal), 32'd0);
    chk("t3_dec_instr", instruction, 32'h0000_0033);
    tick();
    chk("t3_illegal", 32'(illegal), 32'd1);
    chk("t3_halted", 32'(halted), 32'd1);
    chk("t3_req", 32'(mem_req), 32'd0);
    chk("t3_en_n", 32'(alu_imm_enable_n), 32'd1);
    for (int i = 0; i < 3; i++) begin
      mem_ack   = 1'b1;
      mem_rdata = 32'h0051_0093;
      tick();
    end
    mem_ack = 1'b0;
    tick();
    chk("t3_frozen_instr", instruction, 32'h0000_0033);
    chk("t3_frozen_pc", pc, 32'h0);
    chk("t3_still_halted", 32'(halted), 32'd1);
    chk("t3_en_n_late", 32'(alu_imm_enable_n), 32'd1);
    chk("t3_retire", retire_count, 32'd0);

    // Reset asserted during the second EXEC cycle
    hold_reset();
    release_reset();
    do_instr(32'h0010_8093, 0, 32'h0, 32'h0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0020_8113;
    tick();
    mem_ack = 1'b0;
    tick();
    tick();
    chk("t4_exec2_en_n", 32'(alu_imm_enable_n), 32'd0);
    chk("t4_exec2_pc", pc, 32'h4);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_en_n", 32'(alu_imm_enable_n), 32'd1);
    chk("t4_rst_we", 32'(rf_we), 32'd0);
    chk("t4_rst_pc", pc, 32'h0);
    chk("t4_rst_retire", retire_count, 32'd0);
    chk("t4_rst_instr", instruction, 32'h0);
    tick();
    release_reset();
    chk("t4_restart_addr", mem_addr, 32'h0);
    do_instr(32'h0031_8193, 0, 32'h0, 32'h0);

    // PC wrap from the top of the address space
    hold_reset();
    release_reset();
    chk("t5_addr", t_mem_addr, 32'hFFFF_FFFC);
    chk("t5_req", 32'(t_mem_req), 32'd1);
    t_ack   = 1'b1;
    t_rdata = 32'h00A0_0113;
    tick();
    t_ack = 1'b0;
    chk("t5_instr", t_instr, 32'h00A0_0113);
    tick();
    tick();
    tick();
    chk("t5_wb_we", 32'(t_rf_we), 32'd1);
    tick();
    chk("t5_wrap_pc", t_pc, 32'h0);
    chk("t5_wrap_addr", t_mem_addr, 32'h0);
    chk("t5_next_req", 32'(t_mem_req), 32'd1);
    chk("t5_retire", t_retire, 32'd1);

`ifdef FETCH_TIMEOUT_EN
    // Fetch timeout with no ack, then ack arriving in the last allowed cycle
    hold_reset();
    release_reset();
    for (int i = 1; i < 16; i++) tick();
    chk("t6_pre_bus_err", 32'(bus_err), 32'd0);
    chk("t6_pre_req", 32'(mem_req), 32'd1);
    tick();
    chk("t6_bus_err", 32'(bus_err), 32'd1);
    chk("t6_halted", 32'(halted), 32'd1);
    chk("t6_req", 32'(mem_req), 32'd0);
    hold_reset();
    release_reset();
    for (int i = 1; i < 16; i++) tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'h0051_0093;
    tick();
    mem_ack = 1'b0;
    chk("t6_ack_bus_err", 32'(bus_err), 32'd0);
    chk("t6_ack_halted", 32'(halted), 32'd0);
    chk("t6_ack_instr", instruction, 32'h0051_0093);
    tick();
    tick();
    tick();
    chk("t6_ack_wb_we", 32'(rf_we), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
